cl_capture_packer: RTL and testbench

- Parametrised successor to the Camera Link capture block. Runs entirely in the cl_clk domain; frame and line edges are detected synchronously rather than by clocking on fval/lval.
- Captures a commanded number of frames from N_PORTS 8-bit taps. Applies a column ROI window and line decimation, and tags each beat with frame/line/column indices and SOF/SOL flags.
- Buffers beats in an internal first-word-fall-through FIFO toward the PC-bound message path, counting any beats dropped on overflow.

---
 rtl/cl_capture_packer.sv | 201 ++++++++++++++++++++
 tb/tb_cl_capture_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_capture_packer.sv
// rtl/cl_capture_packer.sv - Camera Link frame capture with ROI/decimation tagging and FWFT output FIFO
module cl_capture_packer #(
    parameter int N_PORTS = 10,
    parameter int FRAME_W = 20,
    parameter int LINE_W  = 12,
    parameter int COL_W   = 10,
    parameter int FIFO_AW = 9,
    parameter int OVF_W   = 16
) (
    input  logic                                         cl_clk,
    input  logic                                         reset_n,
    input  logic                                         cl_fval,
    input  logic                                         cl_lval,
    input  logic [8*N_PORTS-1:0]                         cl_data,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [1:0]                                   cmd_op,
    input  logic [31:0]                                  cmd_arg,
    output logic [LINE_W+FRAME_W+COL_W+2+8*N_PORTS-1:0]  out_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic                                         capture_done,
    output logic [OVF_W-1:0]                             ovf_cnt,
    output logic [2:0]                                   led
);
    localparam int PIX_W = 8*N_PORTS;
    localparam int OUT_W = LINE_W+FRAME_W+COL_W+2+PIX_W;
    localparam int DEPTH = 2**FIFO_AW;

    localparam logic [1:0] OP_ARM       = 2'd0;
    localparam logic [1:0] OP_ABORT     = 2'd1;
    localparam logic [1:0] OP_SET_ROI   = 2'd2;
    localparam logic [1:0] OP_SET_DECIM = 2'd3;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURING, DRAIN} state_t;

    state_t             state, state_nxt;
    logic               fval_q, lval_q, fval_d, lval_d;
    logic [PIX_W-1:0]   data_q;
    logic               fval_rise, fval_fall, lval_rise, lval_fall;
    logic [COL_W-1:0]   col_start, col_end, col_q, col_cur;
    logic [7:0]         decim, decim_cnt, decim_cur;
    logic [LINE_W-1:0]  line_q, line_cur;
    logic [FRAME_W-1:0] frames_left, frame_idx;
    logic               sof_pending, sol_pending, sof_cur, sol_cur;
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic               fifo_full, fifo_empty;
    logic               push_req, push_ok, pop, drop;
    logic               cmd_fire, arm_fire, abort_fire, idle_cfg;
    logic               unused_arg;

    always_ff @(posedge cl_clk or negedge reset_n) begin
        if (!reset_n) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            fval_d <= 1'b0;
            lval_d <= 1'b0;
            data_q <= '0;
        end else begin
            fval_q <= cl_fval;
            lval_q <= cl_lval;
            fval_d <= fval_q;
            lval_d <= lval_q;
            data_q <= cl_data;
        end
    end

    assign fval_rise = fval_q & ~fval_d;
    assign fval_fall = ~fval_q & fval_d;
    assign lval_rise = lval_q & ~lval_d;
    assign lval_fall = ~lval_q & lval_d;

    // Only ABORT may interrupt a capture; configuration is frozen outside IDLE.
    assign cmd_ready  = (state == IDLE) || (cmd_op == OP_ABORT);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign abort_fire = cmd_fire && (cmd_op == OP_ABORT);
    assign idle_cfg   = cmd_fire && (state == IDLE);
    assign arm_fire   = idle_cfg && (cmd_op == OP_ARM) && (cmd_arg[FRAME_W-1:0] != '0);
    assign unused_arg = ^cmd_arg;

    // Counter values seen by the current beat, including edges detected this cycle.
    assign col_cur   = lval_rise ? '0 : col_q;
    assign line_cur  = fval_rise ? '0 : line_q;
    assign decim_cur = fval_rise ? 8'd0 : decim_cnt;
    assign sof_cur   = fval_rise | sof_pending;
    assign sol_cur   = lval_rise | sol_pending;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign out_valid  = !fifo_empty;
    assign out_data   = mem[rd_ptr[FIFO_AW-1:0]];
    assign pop        = out_valid && out_ready;

    assign push_req = (state == CAPTURING) && fval_q && lval_q && (decim_cur == 8'd0) &&
                      (col_cur >= col_start) && (col_cur <= col_end) && !abort_fire;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    always_ff @(posedge cl_clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            line_q      <= '0;
            decim_cnt   <= 8'd0;
            sof_pending <= 1'b0;
            sol_pending <= 1'b0;
        end else begin
            if (lval_q)
                col_q <= (&col_cur) ? col_cur : col_cur + COL_W'(1);
            if (fval_rise) begin
                line_q    <= '0;
                decim_cnt <= 8'd0;
            end else if (lval_fall && fval_d) begin
                line_q    <= line_q + LINE_W'(1);
                decim_cnt <= (decim_cnt >= decim) ? 8'd0 : decim_cnt + 8'd1;
            end
            // A dropped flagged beat leaves its flag pending for the next accepted beat.
            sof_pending <= push_ok ? 1'b0 : sof_cur;
            sol_pending <= push_ok ? 1'b0 : sol_cur;
        end
    end

    always_ff @(posedge cl_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort_fire) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge cl_clk) begin
        if (push_ok)
            mem[wr_ptr[FIFO_AW-1:0]] <= {line_cur, frame_idx, col_cur, sof_cur, sol_cur, data_q};
    end

    always_ff @(posedge cl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            frames_left <= '0;
            frame_idx   <= '0;
            col_start   <= '0;
            col_end     <= '1;
            decim       <= 8'd0;
            ovf_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (arm_fire) begin
                frames_left <= cmd_arg[FRAME_W-1:0];
                frame_idx   <= '0;
                ovf_cnt     <= '0;
            end else begin
                if (state == CAPTURING && fval_fall && !abort_fire) begin
                    frames_left <= frames_left - FRAME_W'(1);
                    frame_idx   <= frame_idx + FRAME_W'(1);
                end
                if (drop && !(&ovf_cnt))
                    ovf_cnt <= ovf_cnt + OVF_W'(1);
            end
            if (idle_cfg && cmd_op == OP_SET_ROI) begin
                col_start <= cmd_arg[COL_W-1:0];
                col_end   <= cmd_arg[16 +: COL_W];
            end
            if (idle_cfg && cmd_op == OP_SET_DECIM)
                decim <= cmd_arg[7:0];
        end
    end

    always_comb begin
        state_nxt    = state;
        capture_done = 1'b0;
        case (state)
            IDLE:      if (arm_fire) state_nxt = ARMED;
            ARMED:     if (fval_rise) state_nxt = CAPTURING;
            CAPTURING: if (fval_fall && frames_left == FRAME_W'(1)) state_nxt = DRAIN;
            DRAIN: begin
                if (fifo_empty) begin
                    capture_done = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default:   state_nxt = IDLE;
        endcase
        if (abort_fire) begin
            state_nxt    = IDLE;
            capture_done = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign led  = {fifo_full, out_valid, fval_q};

endmodule

// File: tb/tb_cl_capture_packer.sv
// tb/tb_cl_capture_packer.sv - directed vector bench for cl_capture_packer
module tb_cl_capture_packer;
    localparam int N_PORTS = 2;
    localparam int FRAME_W = 20;
    localparam int LINE_W  = 12;
    localparam int COL_W   = 10;
    localparam int FIFO_AW = 2;
    localparam int OVF_W   = 16;
    localparam int PIX_W   = 8*N_PORTS;
    localparam int OUT_W   = LINE_W+FRAME_W+COL_W+2+PIX_W;

    localparam logic [1:0] OP_ARM = 2'd0, OP_ABORT = 2'd1, OP_SET_ROI = 2'd2, OP_SET_DECIM = 2'd3;

    logic              cl_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cl_fval = 1'b0, cl_lval = 1'b0;
    logic [PIX_W-1:0]  cl_data = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [31:0]       cmd_arg = '0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy, capture_done;
    logic [OVF_W-1:0]  ovf_cnt;
    logic [2:0]        led;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_rx = 0;
    logic [OUT_W-1:0] rx[$];

    typedef struct {
        int frames; int lines; int beats; int cs; int ce; int decim; int exp_n;
    } vec_t;
    vec_t vecs[5];

    cl_capture_packer #(
        .N_PORTS(N_PORTS), .FRAME_W(FRAME_W), .LINE_W(LINE_W),
        .COL_W(COL_W), .FIFO_AW(FIFO_AW), .OVF_W(OVF_W)
    ) dut (
        .cl_clk(cl_clk), .reset_n(reset_n), .cl_fval(cl_fval), .cl_lval(cl_lval),
        .cl_data(cl_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .capture_done(capture_done), .ovf_cnt(ovf_cnt), .led(led)
    );

    always #5 cl_clk = ~cl_clk;

    always @(negedge cl_clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) rx.push_back(out_data);
            if (capture_done) begin
                done_cnt++;
                done_rx = rx.size();
            end
        end
    end

    task automatic step();
        @(posedge cl_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input int f, input int l, input int c);
        return {f[3:0], l[3:0], c[7:0]};
    endfunction

    function automatic logic [OUT_W-1:0] mk(input int l, input int f, input int c, input bit sof, input bit sol);
        return {l[LINE_W-1:0], f[FRAME_W-1:0], c[COL_W-1:0], sof, sol, pix(f, l, c)};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_frame(input int f, input int lines, input int beats);
        cl_fval = 1'b1;
        step();
        for (int l = 0; l < lines; l++) begin
            cl_lval = 1'b1;
            for (int c = 0; c < beats; c++) begin
                cl_data = pix(f, l, c);
                step();
            end
            cl_lval = 1'b0;
            cl_data = '0;
            step();
            step();
        end
        cl_fval = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_done(input int dbase);
        for (int k = 0; k < 500 && done_cnt == dbase; k++) step();
        repeat (2) step();
    endtask

    task automatic run_row(input int r);
        vec_t v;
        int base, dbase;
        bit sofp, solp;
        logic [OUT_W-1:0] expq[$];
        v = vecs[r];
        base = rx.size();
        dbase = done_cnt;
        out_ready = 1'b1;
        issue(OP_SET_ROI, {16'(v.ce), 16'(v.cs)});
        issue(OP_SET_DECIM, 32'(v.decim));
        issue(OP_ARM, 32'(v.frames));
        for (int f = 0; f < v.frames; f++) drive_frame(f, v.lines, v.beats);
        wait_done(dbase);
        for (int f = 0; f < v.frames; f++) begin
            sofp = 1'b1;
            for (int l = 0; l < v.lines; l++) begin
                if (l % (v.decim + 1) == 0) begin
                    solp = 1'b1;
                    for (int c = 0; c < v.beats; c++) begin
                        if (c >= v.cs && c <= v.ce) begin
                            expq.push_back(mk(l, f, c, sofp, solp));
                            sofp = 1'b0;
                            solp = 1'b0;
                        end
                    end
                end
            end
        end
        chk($sformatf("row%0d_count", r), 64'(rx.size() - base), 64'(v.exp_n));
        for (int i = 0; i < expq.size(); i++)
            if (base + i < rx.size())
                chk($sformatf("row%0d_beat%0d", r, i), 64'(rx[base+i]), 64'(expq[i]));
        chk($sformatf("row%0d_done_once", r), 64'(done_cnt - dbase), 64'd1);
        chk($sformatf("row%0d_done_after_pops", r), 64'(done_rx - base), 64'(v.exp_n));
        chk($sformatf("row%0d_idle", r), 64'(busy), 64'd0);
    endtask

    initial begin
        int base, dbase;
        vecs[0] = '{2, 4, 8, 0, 1023, 0, 64};
        vecs[1] = '{1, 6, 8, 2, 4,    1, 9};
        vecs[2] = '{1, 3, 5, 3, 1,    0, 0};
        vecs[3] = '{1, 5, 4, 0, 3,    2, 8};
        vecs[4] = '{3, 2, 3, 1, 1023, 0, 12};

        repeat (2) step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_capture_done", 64'(capture_done), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("rst_led", 64'(led), 64'd0);
        reset_n = 1'b1;
        step();

        for (int r = 0; r < 5; r++) run_row(r);

        // Overflow with a 4-deep FIFO, plus first-beat latency and hold stability.
        base = rx.size();
        dbase = done_cnt;
        out_ready = 1'b0;
        issue(OP_SET_ROI, {16'd1023, 16'd0});
        issue(OP_SET_DECIM, 32'd0);
        issue(OP_ARM, 32'd1);
        cl_fval = 1'b1;
        step();
        step();
        cl_lval = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cl_data = pix(0, 0, c);
            step();
            if (c == 0) chk("lat_not_yet", 64'(out_valid), 64'd0);
            if (c == 1) begin
                chk("lat_valid", 64'(out_valid), 64'd1);
                chk("lat_data", 64'(out_data), 64'(mk(0, 0, 0, 1'b1, 1'b1)));
            end
        end
        cl_lval = 1'b0;
        step();
        chk("ovf_count", 64'(ovf_cnt), 64'd6);
        chk("ovf_led", 64'(led), 64'b111);
        chk("ovf_hold_data", 64'(out_data), 64'(mk(0, 0, 0, 1'b1, 1'b1)));
        cmd_op = OP_SET_ROI;
        #1;
        chk("busy_roi_refused", 64'(cmd_ready), 64'd0);
        cl_fval = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        wait_done(dbase);
        chk("ovf_rx_count", 64'(rx.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < rx.size())
                chk($sformatf("ovf_beat%0d", i), 64'(rx[base+i]), 64'(mk(0, 0, i, i == 0, i == 0)));
        chk("ovf_retained", 64'(ovf_cnt), 64'd6);
        chk("ovf_done_once", 64'(done_cnt - dbase), 64'd1);

        // ARM while a frame is already in progress: the partial frame is skipped.
        base = rx.size();
        dbase = done_cnt;
        cl_fval = 1'b1;
        step();
        cl_lval = 1'b1;
        cl_data = 16'hdead;
        cmd_valid = 1'b1;
        cmd_op = OP_ARM;
        cmd_arg = 32'd1;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        cl_lval = 1'b0;
        step();
        step();
        cl_lval = 1'b1;
        repeat (4) step();
        cl_lval = 1'b0;
        step();
        step();
        cl_fval = 1'b0;
        repeat (3) step();
        chk("midarm_no_push", 64'(rx.size() - base), 64'd0);
        chk("midarm_busy", 64'(busy), 64'd1);
        drive_frame(0, 2, 4);
        wait_done(dbase);
        chk("midarm_count", 64'(rx.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < rx.size())
                chk($sformatf("midarm_beat%0d", i), 64'(rx[base+i]),
                    64'(mk(i / 4, 0, i % 4, i == 0, i % 4 == 0)));

        // ABORT with three beats queued.
        dbase = done_cnt;
        out_ready = 1'b0;
        issue(OP_ARM, 32'd1);
        cl_fval = 1'b1;
        step();
        step();
        cl_lval = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cl_data = pix(0, 0, c);
            step();
        end
        cl_lval = 1'b0;
        step();
        chk("abort_queued", 64'(out_valid), 64'd1);
        cmd_valid = 1'b1;
        cmd_op = OP_ABORT;
        #1;
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_flushed", 64'(out_valid), 64'd0);
        cl_fval = 1'b0;
        repeat (5) step();
        chk("abort_no_done", 64'(done_cnt - dbase), 64'd0);
        cmd_op = OP_SET_ROI;
        #1;
        chk("abort_roi_ready", 64'(cmd_ready), 64'd1);
        issue(OP_SET_ROI, {16'd1023, 16'd0});

        // Asynchronous reset in the middle of a line.
        issue(OP_ARM, 32'd1);
        cl_fval = 1'b1;
        step();
        step();
        cl_lval = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cl_data = pix(0, 0, c);
            step();
        end
        chk("pre_rst_ovf", 64'(ovf_cnt), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("arst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("arst_led", 64'(led), 64'd0);
        chk("arst_capture_done", 64'(capture_done), 64'd0);
        cl_lval = 1'b0;
        cl_fval = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
